// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for a shared-memory RV32I datapath.
// One instruction phase per state; strobes gated off while reset is high.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        HALT
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRC_PC    = 2'b00;
    localparam logic [1:0] SRC_OLDPC = 2'b01;
    localparam logic [1:0] SRC_RS1   = 2'b10;
    localparam logic [1:0] SRC_RS2   = 2'b00;
    localparam logic [1:0] SRC_IMM   = 2'b01;
    localparam logic [1:0] SRC_FOUR  = 2'b10;
    localparam logic [1:0] RES_OUT   = 2'b00;
    localparam logic [1:0] RES_DATA  = 2'b01;
    localparam logic [1:0] RES_ALU   = 2'b10;

    state_t state;
    state_t state_nx;

    logic is_lw;
    logic is_sw;
    logic is_r;
    logic is_i;
    logic is_beq;
    logic is_jal;
    logic f3_ok;

    logic req_c;
    logic mw_c;
    logic irw_c;
    logic pcw_c;
    logic rw_c;
    logic retire;
    logic [2:0] alu_ex;

    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_beq = (opcode == OP_BEQ);
    assign is_jal = (opcode == OP_JAL);
    assign f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                    (funct3 == 3'b110) || (funct3 == 3'b111);

    // State register; reset abandons any access and restarts in FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_nx;
        end
    end

    // ALU operation for register/immediate execute phases
    always_comb begin
        alu_ex = ALU_ADD;
        case (funct3)
            3'b000: begin
                if (state == EXECR && funct7b5) begin
                    alu_ex = ALU_SUB;
                end else begin
                    alu_ex = ALU_ADD;
                end
            end
            3'b010:  alu_ex = ALU_SLT;
            3'b110:  alu_ex = ALU_OR;
            3'b111:  alu_ex = ALU_AND;
            default: alu_ex = ALU_ADD;
        endcase
    end

    // Next-state and per-phase datapath controls
    always_comb begin
        state_nx   = state;
        req_c      = 1'b0;
        mw_c       = 1'b0;
        irw_c      = 1'b0;
        pcw_c      = 1'b0;
        rw_c       = 1'b0;
        retire     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;
        case (state)
            FETCH: begin
                req_c     = 1'b1;
                ALUSrcA   = SRC_PC;
                ALUSrcB   = SRC_FOUR;
                ResultSrc = RES_ALU;
                irw_c     = mem_ready;
                pcw_c     = mem_ready;
                if (mem_ready) begin
                    state_nx = DECODE;
                end
            end
            DECODE: begin
                // branch target lands in ALUOut for BEQ
                ALUSrcA = SRC_OLDPC;
                ALUSrcB = SRC_IMM;
                unique case (1'b1)
                    is_lw, is_sw:            state_nx = MEMADR;
                    is_r && f3_ok:           state_nx = EXECR;
                    is_i && f3_ok:           state_nx = EXECI;
                    is_beq && funct3 == 3'b0: state_nx = BEQ;
                    is_jal:                  state_nx = JAL;
                    default:                 state_nx = HALT;
                endcase
            end
            MEMADR: begin
                ALUSrcA  = SRC_RS1;
                ALUSrcB  = SRC_IMM;
                state_nx = is_sw ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_nx = MEMWB;
                end
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                rw_c      = 1'b1;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            MEMWRITE: begin
                req_c  = 1'b1;
                AdrSrc = 1'b1;
                mw_c   = 1'b1;
                if (mem_ready) begin
                    retire   = 1'b1;
                    state_nx = FETCH;
                end
            end
            EXECR: begin
                ALUSrcA    = SRC_RS1;
                ALUSrcB    = SRC_RS2;
                ALUControl = alu_ex;
                state_nx   = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = SRC_RS1;
                ALUSrcB    = SRC_IMM;
                ALUControl = alu_ex;
                state_nx   = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_OUT;
                rw_c      = 1'b1;
                retire    = 1'b1;
                state_nx  = FETCH;
            end
            BEQ: begin
                ALUSrcA    = SRC_RS1;
                ALUSrcB    = SRC_RS2;
                ALUControl = ALU_SUB;
                ResultSrc  = RES_OUT;
                pcw_c      = zero;
                retire     = 1'b1;
                state_nx   = FETCH;
            end
            JAL: begin
                // PC <- target now, rd <- PC+4 in ALUWB
                ALUSrcA   = SRC_OLDPC;
                ALUSrcB   = SRC_FOUR;
                ResultSrc = RES_OUT;
                pcw_c     = 1'b1;
                state_nx  = ALUWB;
            end
            HALT: begin
                state_nx = HALT;
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        ImmSrc = 2'b00;
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    assign mem_req  = req_c & ~rst;
    assign MemWrite = mw_c & ~rst;
    assign IRWrite  = irw_c & ~rst;
    assign PCWrite  = pcw_c & ~rst;
    assign RegWrite = rw_c & ~rst;
    assign halted   = (state == HALT);

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
        end else if (retire) begin
            retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: a driver pushes per-cycle expected
// controls from an instruction-level model, a monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        RegWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        halted;
    logic [31:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .halted(halted), .retired(retired)
    );

    typedef struct packed {
        logic        req;
        logic        adr;
        logic        mwr;
        logic        irw;
        logic        pcw;
        logic        rw;
        logic [1:0]  rs;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic [1:0]  imm;
        logic [2:0]  alu;
        logic        hlt;
        logic [31:0] ret;
    } rec_t;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    rec_t        q[$];
    string       tq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = '0;
    logic [6:0]  cur_op = '0;
    logic [2:0]  cur_f3 = '0;
    logic        cur_f7 = 1'b0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BQ) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    // add=000 sub=001 and=010 or=011 slt=101
    function automatic logic [2:0] alu_of(input logic [2:0] f3,
                                          input logic sub);
        if (f3 == 3'd0) return sub ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    function automatic rec_t base();
        rec_t r;
        r     = '0;
        r.imm = imm_of(cur_op);
        r.ret = exp_ret;
        return r;
    endfunction

    function automatic rec_t fetch_rec(input logic rdy);
        rec_t r;
        r     = base();
        r.req = 1'b1;
        r.sb  = 2'b10;
        r.rs  = 2'b10;
        r.irw = rdy;
        r.pcw = rdy;
        return r;
    endfunction

    // one clock of stimulus plus its expected response
    task automatic step(input logic r, input logic rdy, input logic zr,
                        input rec_t e, input string tag);
        @(posedge clk);
        #1;
        rst       = r;
        mem_ready = rdy;
        zero      = zr;
        opcode    = cur_op;
        funct3    = cur_f3;
        funct7b5  = cur_f7;
        q.push_back(e);
        tq.push_back(tag);
    endtask

    task automatic rst_cycles(input int n);
        rec_t e;
        exp_ret = '0;
        for (int i = 0; i < n; i++) begin
            e     = base();
            e.sb  = 2'b10;
            e.rs  = 2'b10;
            step(1'b1, rb(), rb(), e, "reset");
        end
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int fw, input int mw,
                             input int halt_n, input int abort_w,
                             input int zsel);
        rec_t e;
        logic lw, sw, r, it, bq, jl, legal, z, f3ok;
        cur_op = op;
        cur_f3 = f3;
        cur_f7 = f7;
        lw = (op == LW);
        sw = (op == SW);
        r  = (op == RT);
        it = (op == IT);
        bq = (op == BQ);
        jl = (op == JL);
        f3ok  = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
        legal = lw || sw || jl || (bq && f3 == 0) || ((r || it) && f3ok);
        for (int i = 0; i < fw; i++) begin
            e = fetch_rec(1'b0);
            step(1'b0, 1'b0, rb(), e, "fetch_wait");
        end
        e = fetch_rec(1'b1);
        step(1'b0, 1'b1, rb(), e, "fetch");
        e    = base();
        e.sa = 2'b01;
        e.sb = 2'b01;
        step(1'b0, rb(), rb(), e, "decode");
        if (!legal) begin
            for (int i = 0; i < halt_n; i++) begin
                e     = base();
                e.hlt = 1'b1;
                step(1'b0, rb(), rb(), e, "halt");
            end
            rst_cycles(1 + int'($urandom_range(0, 1)));
            return;
        end
        if (lw || sw) begin
            e    = base();
            e.sa = 2'b10;
            e.sb = 2'b01;
            step(1'b0, rb(), rb(), e, "memadr");
            for (int i = 0; i < mw; i++) begin
                if (sw && i == abort_w) begin
                    rst_cycles(2);
                    return;
                end
                e     = base();
                e.req = 1'b1;
                e.adr = 1'b1;
                e.mwr = sw;
                step(1'b0, 1'b0, rb(), e, sw ? "memwrite_wait" : "memread_wait");
            end
            e     = base();
            e.req = 1'b1;
            e.adr = 1'b1;
            e.mwr = sw;
            step(1'b0, 1'b1, rb(), e, sw ? "memwrite" : "memread");
            if (sw) begin
                exp_ret++;
                return;
            end
            e    = base();
            e.rs = 2'b01;
            e.rw = 1'b1;
            step(1'b0, rb(), rb(), e, "memwb");
            exp_ret++;
            return;
        end
        if (r || it) begin
            e     = base();
            e.sa  = 2'b10;
            e.sb  = r ? 2'b00 : 2'b01;
            e.alu = alu_of(f3, r && f7);
            step(1'b0, rb(), rb(), e, r ? "execr" : "execi");
            e    = base();
            e.rw = 1'b1;
            step(1'b0, rb(), rb(), e, "aluwb");
            exp_ret++;
            return;
        end
        if (bq) begin
            z     = (zsel < 0) ? rb() : 1'(zsel);
            e     = base();
            e.sa  = 2'b10;
            e.alu = 3'b001;
            e.pcw = z;
            step(1'b0, rb(), z, e, "beq");
            exp_ret++;
            return;
        end
        e     = base();
        e.sa  = 2'b01;
        e.sb  = 2'b10;
        e.pcw = 1'b1;
        step(1'b0, rb(), rb(), e, "jal");
        e    = base();
        e.rw = 1'b1;
        step(1'b0, rb(), rb(), e, "jal_aluwb");
        exp_ret++;
    endtask

    // monitor: pop one expected record per presented cycle
    initial begin
        rec_t a;
        rec_t e;
        string t;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e     = q.pop_front();
                t     = tq.pop_front();
                a.req = mem_req;
                a.adr = AdrSrc;
                a.mwr = MemWrite;
                a.irw = IRWrite;
                a.pcw = PCWrite;
                a.rw  = RegWrite;
                a.rs  = ResultSrc;
                a.sa  = ALUSrcA;
                a.sb  = ALUSrcB;
                a.imm = ImmSrc;
                a.alu = ALUControl;
                a.hlt = halted;
                a.ret = retired;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s t=%0t got %h expected %h (retired %0d vs %0d)",
                             t, $time, a, e, a.ret, e.ret);
                end
            end
        end
    end

    initial begin
        logic [2:0] f3s [4];
        logic [6:0] op;
        logic [2:0] f3;
        int k;
        int mw;
        f3s = '{3'd0, 3'd2, 3'd6, 3'd7};
        rst_cycles(3);
        run_instr(RT, 3'd0, 1'b1, 0, 0, 0, -1, -1);
        run_instr(LW, 3'd2, 1'b0, 0, 3, 0, -1, -1);
        run_instr(BQ, 3'd0, 1'b0, 0, 0, 0, -1, 1);
        run_instr(BQ, 3'd0, 1'b0, 0, 0, 0, -1, 0);
        run_instr(JL, 3'd3, 1'b0, 0, 0, 0, -1, -1);
        run_instr(7'd0, 3'd0, 1'b0, 0, 0, 20, -1, -1);
        run_instr(SW, 3'd2, 1'b0, 1, 5, 0, 2, -1);
        run_instr(IT, 3'd0, 1'b1, 1, 0, 0, -1, -1);
        for (int n = 0; n < 400; n++) begin
            k  = int'($urandom_range(0, 19));
            mw = int'($urandom_range(0, 3));
            f3 = f3s[$urandom_range(0, 3)];
            if (k <= 3) begin
                run_instr(RT, f3, rb(), int'($urandom_range(0, 2)), 0, 0, -1, -1);
            end else if (k <= 6) begin
                run_instr(IT, f3, rb(), int'($urandom_range(0, 2)), 0, 0, -1, -1);
            end else if (k <= 9) begin
                run_instr(LW, 3'($urandom), rb(), int'($urandom_range(0, 2)), mw, 0, -1, -1);
            end else if (k <= 12) begin
                run_instr(SW, 3'($urandom), rb(), int'($urandom_range(0, 2)), mw, 0, -1, -1);
            end else if (k <= 15) begin
                run_instr(BQ, 3'd0, rb(), int'($urandom_range(0, 2)), 0, 0, -1, -1);
            end else if (k <= 17) begin
                run_instr(JL, 3'($urandom), rb(), int'($urandom_range(0, 2)), 0, 0, -1, -1);
            end else if (k == 18) begin
                case ($urandom_range(0, 2))
                    0: begin
                        do op = 7'($urandom);
                        while (op == LW || op == SW || op == RT ||
                               op == IT || op == BQ || op == JL);
                        run_instr(op, 3'($urandom), rb(), 0, 0, 4, -1, -1);
                    end
                    1: begin
                        f3 = 3'($urandom_range(0, 1) ? 1 : 3);
                        if (rb()) f3 = 3'($urandom_range(4, 5));
                        run_instr(rb() ? RT : IT, f3, rb(), 0, 0, 3, -1, -1);
                    end
                    default: begin
                        run_instr(BQ, 3'($urandom_range(1, 7)), rb(), 0, 0, 3, -1, -1);
                    end
                endcase
            end else begin
                mw = int'($urandom_range(2, 4));
                run_instr(SW, 3'd2, 1'b0, 0, mw, 0,
                          int'($urandom_range(0, mw - 1)), -1);
            end
        end
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d records left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
